// File: rtl/mul9_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul9_pkg
// Description : Shared types, sizes and column-geometry helpers for the
//               9x9 shift-register multiplier sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mul9_pkg;

    localparam int WIDTH = 9;
    localparam int NCOLS = 2 * WIDTH - 1;
    localparam int NDST  = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Number of partial products landing in column k.
    function automatic int col_height(input int k);
        return (k + 1 < NCOLS - k) ? k + 1 : NCOLS - k;
    endfunction

    // Lowest multiplicand bit index contributing to column k.
    function automatic int col_base(input int k);
        return (k > WIDTH - 1) ? k - (WIDTH - 1) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
// Module      : shift_register
// Description : Per-column partial-product shift registers feeding a
//               column compressor (weighted popcount sum).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register
    import mul9_pkg::*;
(
    input  logic             clk,
    input  logic             shift_en,
    input  logic [NCOLS-1:0] sin,
    output logic [NDST-1:0]  dst
);

    logic [3:0] w_cnt [NCOLS];

    generate
        for (genvar k = 0; k < NCOLS; k++) begin : g_col
            localparam int c_h = col_height(k);
            logic [c_h-1:0] r_col;

            if (c_h == 1) begin : g_single
                always_ff @(posedge clk) begin
                    if (shift_en) r_col <= sin[k];
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (shift_en) r_col <= {r_col[c_h-2:0], sin[k]};
                end
            end

            assign w_cnt[k] = 4'($countones(r_col));
        end
    endgenerate

    always_comb begin
        dst = '0;
        for (int k = 0; k < NCOLS; k++) begin
            dst = dst + (NDST'(w_cnt[k]) << k);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul9_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul9_sequencer
// Description : Handshaked controller that serially loads a 9x9 partial
//               product array, captures the compressed result and checks it.
// Revision    : 1.0 - initial release
// ============================================================================
module mul9_sequencer #(
    parameter int WIDTH         = 9,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*WIDTH:0] out_product,
    output logic             out_mismatch,
    output logic [15:0]      err_count,
    output logic             busy
);
    import mul9_pkg::*;

    localparam logic [3:0] c_last_t      = 4'(WIDTH - 1);
    localparam logic [3:0] c_last_settle = 4'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_t;
    logic [3:0]          r_settle;
    logic [3:0]          w_e;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_ref;
    logic [NCOLS-1:0]    w_sin;
    logic [NDST-1:0]     w_dst;
    logic [NDST-1:0]     r_product;
    logic                r_mismatch;
    logic [15:0]         r_err;
    logic                w_load;
    logic                w_capture;
    logic                w_mismatch;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid)                   w_state_nxt = ST_LOAD;
            ST_LOAD:   if (r_t == c_last_t)            w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_settle == c_last_settle)  w_state_nxt = ST_DONE;
            ST_DONE:   if (out_ready)                  w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign out_product  = r_product;
    assign out_mismatch = r_mismatch;
    assign err_count    = r_err;
    assign w_load       = (r_state == ST_LOAD);
    assign w_capture    = (r_state == ST_SETTLE) && (r_settle == c_last_settle);
    assign w_mismatch   = (w_dst != {1'b0, r_ref});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_t        <= 4'd0;
            r_settle   <= 4'd0;
            r_product  <= '0;
            r_mismatch <= 1'b0;
            r_err      <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= (w_load && r_t != c_last_t) ? r_t + 4'd1 : 4'd0;
            r_settle <= (r_state == ST_SETTLE && !w_capture) ? r_settle + 4'd1 : 4'd0;
            if (w_capture) begin
                r_product  <= w_dst;
                r_mismatch <= w_mismatch;
                if (w_mismatch && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            end
        end
    end

    // Operands and the reference product are datapath-only; no reset needed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_ref <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
        end
    end

    // Deepest entries enter first so the last shift places entry 0 at the head.
    assign w_e = c_last_t - r_t;

    generate
        for (genvar k = 0; k < NCOLS; k++) begin : g_col
            localparam int c_h  = col_height(k);
            localparam int c_i0 = col_base(k);
            logic [WIDTH-1:0] w_pp;

            for (genvar e = 0; e < WIDTH; e++) begin : g_ent
                if (e < c_h) begin : g_live
                    assign w_pp[e] = r_a[c_i0+e] & r_b[k-c_i0-e];
                end else begin : g_pad
                    assign w_pp[e] = 1'b0;
                end
            end

            assign w_sin[k] = w_load & w_pp[w_e];
        end
    endgenerate

    shift_register u_dp (
        .clk      (clk),
        .shift_en (w_load),
        .sin      (w_sin),
        .dst      (w_dst)
    );

endmodule
`default_nettype wire

// File: tb/tb_mul9_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul9_sequencer
// Description : Scoreboard bench for mul9_sequencer with directed corners
//               and randomized back-to-back operand traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul9_sequencer;

    localparam int c_lat = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_a;
    logic [8:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_product;
    logic        out_mismatch;
    logic [15:0] err_count;
    logic        busy;

    logic        ready_hold;
    logic        ready_rnd;
    logic        rand_mode;
    logic        prev_valid;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          model_err = 0;

    typedef struct {
        logic [18:0] prod;
        logic        mm;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    assign out_ready = rand_mode ? ready_rnd : ready_hold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) ready_rnd = ($urandom_range(0, 3) != 0);

    mul9_sequencer #(
        .WIDTH         (9),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_mismatch (out_mismatch),
        .err_count    (err_count),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one operand pair; expected result is pushed at the accept edge.
    task automatic send(input logic [8:0] a, input logic [8:0] b, input bit push, input bit forced);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.prod = forced ? 19'd0 : 19'(a * b);
            e.mm   = forced;
            e.acc  = cyc;
            exp_q.push_back(e);
            if (forced) model_err++;
        end
        in_valid = 1'b0;
        in_a     = 9'($urandom);
        in_b     = 9'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),     32'd1);
        check({tag, "_out_valid"}, 32'(out_valid),    32'd0);
        check({tag, "_product"},   32'(out_product),  32'd0);
        check({tag, "_mismatch"},  32'(out_mismatch), 32'd0);
        check({tag, "_err_count"}, 32'(err_count),    32'd0);
        check({tag, "_busy"},      32'(busy),         32'd0);
    endtask

    // Monitor: pops the scoreboard whenever a new result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b0) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product",          32'(out_product),  32'(e.prod));
                    check("mismatch",         32'(out_mismatch), 32'(e.mm));
                    check("latency",          32'(cyc - e.acc),  32'(c_lat));
                    check("in_ready_in_done", 32'(in_ready),     32'd0);
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        ready_hold = 1'b1;
        rand_mode  = 1'b0;
        prev_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Basic product with busy held until the result appears.
        send(9'd3, 9'd5, 1'b1, 1'b0);
        for (int i = 0; i < c_lat; i++) begin
            @(negedge clk);
            check("busy_before_valid", {30'd0, busy, out_valid}, 32'b10);
        end
        drain();

        send(9'd511, 9'd511, 1'b1, 1'b0);
        drain();
        send(9'd0, 9'd300, 1'b1, 1'b0);
        drain();

        // Consumer stall: result must hold with no new accept.
        ready_hold = 1'b0;
        send(9'd100, 9'd200, 1'b1, 1'b0);
        for (int n = 0; n < 30 && !out_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",    32'(out_valid),   32'd1);
            check("stall_product",  32'(out_product), 32'd20000);
            check("stall_in_ready", 32'(in_ready),    32'd0);
        end
        ready_hold = 1'b1;
        drain();

        // Abort mid-load, then a clean transaction.
        send(9'd2, 9'd3, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready),  32'd1);
        check("abort_busy",     32'(busy),      32'd0);
        check("abort_valid",    32'(out_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        send(9'd7, 9'd9, 1'b1, 1'b0);
        drain();

        // Corrupted compressor output must be flagged and counted.
        force dut.w_dst = '0;
        send(9'd1, 9'd1, 1'b1, 1'b1);
        drain();
        release dut.w_dst;
        check("forced_err_count", 32'(err_count), 32'(model_err));

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_err = 0;
        check("reset_err_count", 32'(err_count), 32'd0);

        // Back-to-back random traffic with a randomly stalling consumer.
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(9'($urandom), 9'($urandom), 1'b1, 1'b0);
        end
        drain();
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("final_err_count", 32'(err_count), 32'(model_err));
        check("final_queue",     32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
